// File: rtl/hdlc_frame_tx.sv
// Serial HDLC/422 command-frame transmitter: {HDR, payload} shifted MSB-first at DIV clocks per bit.
// Optional CRC-16/CCITT-FALSE trailer is enabled by defining HDLC_TX_CRC_EN.
module hdlc_frame_tx #(
    parameter int                DATA_W = 32,
    parameter int                HDR_W  = 16,
    parameter logic [HDR_W-1:0]  HDR    = 16'h55AA,
    parameter int                DIV    = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    output logic              data_out,
    output logic              busy,
    output logic              finish
);

    localparam int FRAME_W = HDR_W + DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W + 16 + 1);
    localparam int DIV_W   = $clog2(DIV + 1);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);
    localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND
`ifdef HDLC_TX_CRC_EN
        ,
        CRC
`endif
    } state_t;

    state_t               state_reg;
    logic [FRAME_W-1:0]   shift_reg;
    logic [CNT_W-1:0]     bit_cnt_reg;
    logic [DIV_W-1:0]     div_cnt_reg;
    logic                 bit_tick;

    assign bit_tick = (div_cnt_reg == LAST_DIV);

`ifdef HDLC_TX_CRC_EN
    localparam logic [CNT_W-1:0] CRC_LAST = CNT_W'(15);

    logic [15:0] crc_reg;
    logic [15:0] crc_next;

    // CRC absorbs the bit currently on the line, i.e. the shift register MSB
    always_comb begin
        crc_next = {crc_reg[14:0], 1'b0};
        if (crc_reg[15] ^ shift_reg[FRAME_W-1]) begin
            crc_next = crc_next ^ 16'h1021;
        end
    end
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg   <= IDLE;
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
            div_cnt_reg <= '0;
            data_out    <= 1'b0;
            busy        <= 1'b0;
            finish      <= 1'b0;
`ifdef HDLC_TX_CRC_EN
            crc_reg     <= '0;
`endif
        end else begin
            finish <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        shift_reg   <= {HDR, data_in};
                        data_out    <= HDR[HDR_W-1];
                        bit_cnt_reg <= '0;
                        div_cnt_reg <= '0;
                        busy        <= 1'b1;
                        state_reg   <= SEND;
`ifdef HDLC_TX_CRC_EN
                        crc_reg     <= 16'hFFFF;
`endif
                    end
                end

                SEND: begin
                    if (bit_tick) begin
                        div_cnt_reg <= '0;
`ifdef HDLC_TX_CRC_EN
                        crc_reg     <= crc_next;
`endif
                        if (bit_cnt_reg == LAST_BIT) begin
`ifdef HDLC_TX_CRC_EN
                            state_reg   <= CRC;
                            bit_cnt_reg <= '0;
                            data_out    <= crc_next[15];
`else
                            state_reg   <= IDLE;
                            data_out    <= 1'b0;
                            busy        <= 1'b0;
                            finish      <= 1'b1;
`endif
                        end else begin
                            shift_reg   <= shift_reg << 1;
                            data_out    <= shift_reg[FRAME_W-2];
                            bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
                        end
                    end else begin
                        div_cnt_reg <= div_cnt_reg + DIV_W'(1);
                    end
                end

`ifdef HDLC_TX_CRC_EN
                CRC: begin
                    if (bit_tick) begin
                        div_cnt_reg <= '0;
                        if (bit_cnt_reg == CRC_LAST) begin
                            state_reg <= IDLE;
                            data_out  <= 1'b0;
                            busy      <= 1'b0;
                            finish    <= 1'b1;
                        end else begin
                            crc_reg     <= {crc_reg[14:0], 1'b0};
                            data_out    <= crc_reg[14];
                            bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
                        end
                    end else begin
                        div_cnt_reg <= div_cnt_reg + DIV_W'(1);
                    end
                end
`endif

                default: begin
                    state_reg <= IDLE;
                    data_out  <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hdlc_frame_tx.sv
// Randomized self-checking bench for hdlc_frame_tx: expected line bits come from a frame model
// (header/payload bit lists plus CRC by polynomial long division).
module tb_hdlc_frame_tx;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic [63:0] din;
    int          sel;

    logic do_a, busy_a, fin_a;
    logic do_b, busy_b, fin_b;
    logic do_m, busy_m, fin_m;

    int n_checks = 0;
    int n_pass   = 0;

    bit          exp_q[$];
    int          cur_div;
    logic [127:0] last_line;

    always #5 clk = ~clk;

    hdlc_frame_tx dut_a (
        .clk      (clk),
        .rstn     (rstn),
        .start    (start && (sel == 0)),
        .data_in  (din[31:0]),
        .data_out (do_a),
        .busy     (busy_a),
        .finish   (fin_a)
    );

    hdlc_frame_tx #(.DATA_W(1), .HDR_W(1), .HDR(1'b1), .DIV(1)) dut_b (
        .clk      (clk),
        .rstn     (rstn),
        .start    (start && (sel == 1)),
        .data_in  (din[0:0]),
        .data_out (do_b),
        .busy     (busy_b),
        .finish   (fin_b)
    );

`ifdef HDLC_TX_CRC_EN
    logic do_c, busy_c, fin_c;
    hdlc_frame_tx #(.DATA_W(64), .HDR_W(8), .HDR(8'h31), .DIV(1)) dut_c (
        .clk      (clk),
        .rstn     (rstn),
        .start    (start && (sel == 2)),
        .data_in  (din),
        .data_out (do_c),
        .busy     (busy_c),
        .finish   (fin_c)
    );
`endif

    always_comb begin
        do_m   = do_a;
        busy_m = busy_a;
        fin_m  = fin_a;
        if (sel == 1) begin
            do_m   = do_b;
            busy_m = busy_b;
            fin_m  = fin_b;
        end
`ifdef HDLC_TX_CRC_EN
        if (sel == 2) begin
            do_m   = do_c;
            busy_m = busy_c;
            fin_m  = fin_c;
        end
`endif
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s at %0t: got %h, expected %h", tag, $time, got, exp);
    endtask

    // Expected line bits for the selected instance's frame carrying payload d
    task automatic build_expected(input logic [63:0] d);
        int          hw, dw, len;
        logic [63:0] hdr;
        bit          msg[$];
        case (sel)
            1:       begin hw = 1;  dw = 1;  hdr = 64'h1;    cur_div = 1; end
            2:       begin hw = 8;  dw = 64; hdr = 64'h31;   cur_div = 1; end
            default: begin hw = 16; dw = 32; hdr = 64'h55AA; cur_div = 4; end
        endcase
        exp_q.delete();
        for (int i = hw - 1; i >= 0; i--) exp_q.push_back(hdr[i]);
        for (int i = dw - 1; i >= 0; i--) exp_q.push_back(d[i]);
`ifdef HDLC_TX_CRC_EN
        // remainder of (0xFFFF * x^L + M * x^16) mod 0x11021
        len = exp_q.size();
        msg = exp_q;
        for (int i = 0; i < 16; i++) msg.push_back(1'b0);
        for (int i = 0; i < 16; i++) msg[i] = ~msg[i];
        for (int i = 0; i < len; i++) begin
            if (msg[i]) begin
                for (int k = 0; k <= 16; k++) begin
                    logic [16:0] poly;
                    poly = 17'h11021;
                    msg[i+k] = msg[i+k] ^ poly[16-k];
                end
            end
        end
        for (int i = 0; i < 16; i++) exp_q.push_back(msg[len+i]);
`else
        len = 0;
        msg.delete();
`endif
    endtask

    // Caller has driven start=1 / din=d at a negedge. Checks every cycle of the frame.
    task automatic run_frame(input logic [63:0] d, input int hold, input bit chain,
                             input logic [63:0] next_d, input int abort_bit);
        int           n;
        int           dv;
        logic [127:0] line;
        bit           seen_fin, seen_busy;
        build_expected(d);
        n    = exp_q.size();
        dv   = cur_div;
        line = '0;
        for (int j = 0; j < n * dv; j++) begin
            @(negedge clk);
            if (abort_bit >= 0 && j == abort_bit * dv) begin
                start = 1'b0;
                rstn  = 1'b0;
                #1;
                check("abort_data_out", do_m, 0);
                check("abort_busy", busy_m, 0);
                check("abort_finish", fin_m, 0);
                @(negedge clk);
                rstn = 1'b1;
                seen_fin  = 0;
                seen_busy = 0;
                for (int k = 0; k < n * dv + 8; k++) begin
                    @(negedge clk);
                    if (fin_m) seen_fin = 1;
                    if (busy_m) seen_busy = 1;
                end
                check("abort_no_finish", seen_fin, 0);
                check("abort_no_busy", seen_busy, 0);
                return;
            end
            check("data_out", do_m, exp_q[j / dv]);
            check("busy", busy_m, 1);
            check("finish_early", fin_m, 0);
            if (j % dv == dv - 1) line = {line[126:0], do_m};
            if (j + 1 >= hold) start = 1'b0;
            else din = {$urandom, $urandom};
        end
        last_line = line;
        @(negedge clk);
        check("finish", fin_m, 1);
        check("end_busy", busy_m, 0);
        check("end_data_out", do_m, 0);
        if (chain) begin
            start = 1'b1;
            din   = next_d;
        end else begin
            @(negedge clk);
            check("finish_pulse", fin_m, 0);
            check("idle_busy", busy_m, 0);
            check("idle_data_out", do_m, 0);
        end
    endtask

    initial begin
        logic [63:0] d;
        int          crc_bits;
`ifdef HDLC_TX_CRC_EN
        crc_bits = 16;
`else
        crc_bits = 0;
`endif
        rstn  = 1'b0;
        start = 1'b0;
        din   = '0;
        sel   = 0;
        #1;
        check("reset_data_out", do_m, 0);
        check("reset_busy", busy_m, 0);
        check("reset_finish", fin_m, 0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // Known legacy frame
        start = 1'b1;
        din   = 64'h12345678;
        run_frame(64'h12345678, 1, 0, 0, -1);
        check("legacy_frame", 64'(last_line >> crc_bits), 64'h55AA12345678);

        // start held for 100 cycles while din keeps changing
        d = {32'h0, $urandom};
        start = 1'b1;
        din   = d;
        run_frame(d, 100, 0, 0, -1);

        // Back-to-back: second start in the finish cycle
        d = {32'h0, $urandom};
        start = 1'b1;
        din   = d;
        run_frame(d, 1, 1, 64'hA5A5A5A5, -1);
        run_frame(64'hA5A5A5A5, 1, 0, 0, -1);

        // Reset at bit 20, then a clean frame
        d = {32'h0, $urandom};
        start = 1'b1;
        din   = d;
        run_frame(d, 1, 0, 0, 20);
        d = {32'h0, $urandom};
        start = 1'b1;
        din   = d;
        run_frame(d, 1, 0, 0, -1);

        // Random frames with random start hold lengths
        for (int i = 0; i < 6; i++) begin
            d = {32'h0, $urandom};
            start = 1'b1;
            din   = d;
            run_frame(d, int'($urandom_range(1, 60)), 0, 0, -1);
        end

        // Minimal widths, DIV=1
        sel   = 1;
        start = 1'b1;
        din   = 64'h0;
        run_frame(64'h0, 1, 0, 0, -1);
        check("tiny_frame", 64'(last_line >> crc_bits), 64'h2);
        for (int i = 0; i < 3; i++) begin
            d = {63'h0, 1'($urandom)};
            start = 1'b1;
            din   = d;
            run_frame(d, 1, (i == 0), 64'h1, -1);
            if (i == 0) run_frame(64'h1, 1, 0, 0, -1);
        end

`ifdef HDLC_TX_CRC_EN
        sel   = 2;
        start = 1'b1;
        din   = 64'h3233343536373839;
        run_frame(64'h3233343536373839, 1, 0, 0, -1);
        check("crc_check_value", 64'(last_line[15:0]), 64'h29B1);
        d = {$urandom, $urandom};
        start = 1'b1;
        din   = d;
        run_frame(d, 1, 0, 0, -1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hdlc_frame_tx.md
# hdlc_frame_tx

Parametrised serial frame transmitter for the 422/HDLC command path. It succeeds the fixed 48-bit, reset-triggered command sender. A start pulse loads a header plus a payload of configurable width. The frame is shifted out MSB-first at a configurable bit period, with an optional CRC-16 trailer, followed by a one-cycle `finish` pulse. The block sits between the PS-side command register and the RS-422 line driver.

## Interface
Parameters:
- `DATA_W`, 32: payload width in bits, ≥1.
- `HDR_W`, 16: header width in bits, ≥1.
- `HDR`, 16'h55AA: header value, `HDR_W` bits, sent first.
- `DIV`, 4: clk cycles per serial bit, ≥1.

Ports:
- `clk`  in  1: system clock.
- `rstn`  in  1: reset, asynchronous, active-low.
- `start`  in  1: frame request, sampled on the rising edge of `clk`.
- `data_in`  in  `DATA_W`: payload, captured on the accepted `start` edge only.
- `data_out`  out  1: serial line, registered.
- `busy`  out  1: high while a frame is in progress.
- `finish`  out  1: one-cycle pulse after the last bit.

## Operation
- States:
  - IDLE: `busy`=0, `data_out`=0.
  - SEND: header+payload shift.
  - CRC: only with the macro defined.
- IDLE + `start`=1: on that edge, load shift register {`HDR`,`data_in`}, clear bit counter and divider, and go to SEND. `data_out` takes the MSB on the same edge.
- Divider counts 0..`DIV`-1. Each wrap advances one bit: shift left, `data_out` takes the new MSB, bit counter +1.
- SEND lasts `HDR_W`+`DATA_W` bits. After the last bit period:
  - without CRC, return to IDLE;
  - with CRC, go to CRC for 16 bits.
- Returning to IDLE drives `data_out` to 0 and `busy` to 0, and pulses `finish`=1 on that same edge.
- `start` while `busy`=1 is ignored. It is not queued, and `data_in` is not re-sampled.
- `start`=1 in the `finish` cycle is accepted, giving back-to-back frames with one idle cycle (`data_out`=0).
- Bit counter width: clog2(`HDR_W`+`DATA_W`+16+1). Divider width: clog2(`DIV`+1). Both wrap only under state control, never by overflow.
- `rstn` low at any time, including mid-frame: immediate return to IDLE. All counters and shift/CRC registers clear. No `finish` is generated for an aborted frame.

## Timing
- Reset values: `data_out`=0, `busy`=0, `finish`=0.
- Let N = `HDR_W`+`DATA_W` (+16 with CRC), and let edge E accept `start`.
- Bit k (0-based) drives `data_out` from edge E+k·`DIV` to edge E+(k+1)·`DIV`.
- `busy` is high from edge E through edge E+N·`DIV`.
- At edge E+N·`DIV`: `busy`=0, `data_out`=0, `finish`=1 for exactly one cycle.
- Start-to-first-bit latency: 1 edge. Frame length: N·`DIV` cycles.

## Configuration
- `HDLC_TX_CRC_EN` defined:
  - CRC-16/CCITT-FALSE (poly 0x1021, init 0xFFFF, no reflection, no final XOR) is computed over every header and payload bit as it is shifted.
  - The 16 CRC bits are appended MSB-first in state CRC.
  - N = `HDR_W`+`DATA_W`+16.
- Not defined:
  - No CRC logic or CRC state is synthesised.
  - N = `HDR_W`+`DATA_W`, and the line sequence is identical to the fixed 48-bit legacy frame for default parameters.

## Test plan
- Defaults, no CRC, `start` pulse with `data_in`=32'h12345678 → `busy` high for 192 cycles. `data_out` shows 48'h55AA12345678 MSB-first, 4 cycles per bit (first bits 0,1,0,1). `finish`=1 for one cycle at edge E+192.
- `HDLC_TX_CRC_EN`, `HDR_W`=8, `HDR`=8'h31, `DATA_W`=64, `data_in`=64'h3233343536373839 (ASCII "123456789" overall), `DIV`=1 → last 16 line bits = 16'h29B1. `finish` at E+88.
- `start` held high for 100 cycles during a frame → exactly one frame is sent, and the second `data_in` value is never transmitted.
- `start` asserted in the `finish` cycle with `data_in`=32'hA5A5A5A5 → second frame begins at the next edge. There is one cycle of `data_out`=0 between frames.
- `rstn` pulsed low at bit 20 → `data_out`/`busy`/`finish` are 0 immediately and no `finish` follows. The next `start` sends a complete, correct frame.
- `DIV`=1, `DATA_W`=1, `HDR_W`=1, `HDR`=1'b1, `data_in`=0 → `data_out` sequence 1,0. `busy` high for 2 cycles, then `finish`.
